// File: rtl/ws281x_frame_driver.sv
// rtl/ws281x_frame_driver.sv - framed WS281x/SK6812 serial LED chain driver
//
// Purpose: on an accepted start, fetch one pixel per LED from an external
// store, scale it by a brightness value captured at start, and serialise it
// MSB first (G, R, B, then W when RGBW=1) as single-wire NRZ on DO. DO is then
// held low for RESET_CYCLES, after which done pulses for one cycle.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   start        frame request, accepted only while idle
//   brightness   global scale, captured when start is accepted
//   address      pixel index presented to the store
//   red_in, green_in, blue_in, white_in
//                pixel at address (white_in only used when RGBW=1)
//   busy         high from the cycle after acceptance until done
//   done         one-cycle pulse at the end of the latch period
//   DO           serial data to the first LED
module ws281x_frame_driver #(
  parameter int NUM_LEDS     = 8,
  parameter int ADDR_W       = 3,
  parameter int RGBW         = 0,
  parameter int T0H_CYCLES   = 35,
  parameter int T1H_CYCLES   = 70,
  parameter int BIT_CYCLES   = 125,
  parameter int RESET_CYCLES = 5000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        brightness,
  output logic [ADDR_W-1:0] address,
  input  logic [7:0]        red_in,
  input  logic [7:0]        green_in,
  input  logic [7:0]        blue_in,
  input  logic [7:0]        white_in,
  output logic              busy,
  output logic              done,
  output logic              DO
);

  localparam int BPP = (RGBW != 0) ? 32 : 24;
  localparam int CW  = $clog2(BIT_CYCLES);
  localparam int LW  = $clog2(RESET_CYCLES + 1);

  localparam logic [CW-1:0]     CYC_LAST   = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0]     CYC_SAMPLE = CW'(1);
  localparam logic [CW:0]       TH_ZERO    = (CW + 1)'(T0H_CYCLES);
  localparam logic [CW:0]       TH_ONE     = (CW + 1)'(T1H_CYCLES);
  localparam logic [4:0]        BIT_LAST   = 5'(BPP - 1);
  localparam logic [4:0]        BIT_PENULT = 5'(BPP - 2);
  localparam logic [ADDR_W-1:0] LED_LAST   = ADDR_W'(NUM_LEDS - 1);
  localparam logic [LW-1:0]     LAT_LAST   = LW'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SEND,
    S_LATCH
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]     cyc;
  logic [4:0]        bitn;
  logic [ADDR_W-1:0] led;
  logic [LW-1:0]     lat;
  logic [7:0]        bright_q;
  logic [31:0]       sr;
  logic [31:0]       shadow;
  logic [31:0]       scaled_pix;

  logic          bit_end, last_bit, last_led, lat_end;
  logic [CW:0]   cyc_inc;
  logic [CW:0]   th_cur;

  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, c} * ({8'd0, b} + 16'd1);
    return 8'(p >> 8);
  endfunction

  // Pixels are kept left-aligned in 32 bits so the wire bit is always sr[31].
  assign scaled_pix = {scale(green_in, bright_q),
                       scale(red_in, bright_q),
                       scale(blue_in, bright_q),
                       (RGBW != 0) ? scale(white_in, bright_q) : 8'h00};

  assign bit_end  = (cyc == CYC_LAST);
  assign last_bit = (bitn == BIT_LAST);
  assign last_led = (led == LED_LAST);
  assign lat_end  = (lat == LAT_LAST);
  assign cyc_inc  = {1'b0, cyc} + 1'b1;
  assign th_cur   = sr[31] ? TH_ONE : TH_ZERO;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_SEND;
      S_SEND:  if (bit_end && last_bit && last_led) state_d = S_LATCH;
      S_LATCH: if (lat_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc      <= '0;
      bitn     <= '0;
      led      <= '0;
      lat      <= '0;
      bright_q <= '0;
      sr       <= '0;
      shadow   <= '0;
      address  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      DO       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          address <= '0;
          if (start) bright_q <= brightness;
        end
        S_FETCH: begin
          busy <= 1'b1;
        end
        S_LOAD: begin
          // The store has seen address 0 since idle, so LED 0 is sampled here.
          sr   <= scaled_pix;
          cyc  <= '0;
          bitn <= '0;
          led  <= '0;
          DO   <= 1'b1;
        end
        S_SEND: begin
          if (!bit_end) begin
            cyc <= cyc + 1'b1;
            DO  <= (cyc_inc < th_cur);
          end else begin
            cyc <= '0;
            if (!last_bit) begin
              bitn <= bitn + 1'b1;
              sr   <= {sr[30:0], 1'b0};
              DO   <= 1'b1;
              // Entering the final bit: move the store on to the next LED.
              if (bitn == BIT_PENULT && !last_led) address <= led + 1'b1;
            end else if (!last_led) begin
              bitn <= '0;
              led  <= led + 1'b1;
              sr   <= shadow;
              DO   <= 1'b1;
            end else begin
              bitn    <= '0;
              led     <= '0;
              lat     <= '0;
              address <= '0;
              DO      <= 1'b0;
            end
          end
          // Two edges after the prefetch address change the store data is valid.
          if (last_bit && cyc == CYC_SAMPLE && !last_led) shadow <= scaled_pix;
        end
        S_LATCH: begin
          address <= '0;
          if (lat_end) begin
            lat  <= '0;
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            lat <= lat + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ws281x_frame_driver.sv
// tb/tb_ws281x_frame_driver.sv - scoreboard bench for ws281x_frame_driver
module tb_ws281x_frame_driver;

  localparam int N0 = 5, AW0 = 3, T0H0 = 3, T1H0 = 6, BC0 = 10, RC0 = 50;
  localparam int N1 = 1, AW1 = 1, T0H1 = 2, T1H1 = 5, BC1 = 8, RC1 = 20;

  typedef struct {
    int rise;
    int width;
  } pulse_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  logic           start0, start1;
  logic [7:0]     bright0, bright1;
  logic [AW0-1:0] address0;
  logic [AW1-1:0] address1;
  logic [7:0]     red0, green0, blue0, white0;
  logic [7:0]     r1, g1, b1, w1;
  logic           busy0, done0, DO0, busy1, done1, DO1;

  logic [31:0] mem [0:7];
  logic [31:0] rd0;

  pulse_t q0[$];
  pulse_t q1[$];
  int     dq0[$];
  int     dq1[$];
  int     snap [0:7][0:3];
  int     frame_s0 = 0;
  bit     act0 = 1'b0;
  int     n_cmp = 0;
  int     n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pixel store with one registered read stage.
  always @(posedge clk) rd0 <= mem[address0];
  assign green0 = rd0[31:24];
  assign red0   = rd0[23:16];
  assign blue0  = rd0[15:8];
  assign white0 = rd0[7:0];

  ws281x_frame_driver #(
    .NUM_LEDS(N0), .ADDR_W(AW0), .RGBW(0), .T0H_CYCLES(T0H0),
    .T1H_CYCLES(T1H0), .BIT_CYCLES(BC0), .RESET_CYCLES(RC0)
  ) dut (
    .clk(clk), .reset(reset), .start(start0), .brightness(bright0),
    .address(address0), .red_in(red0), .green_in(green0), .blue_in(blue0),
    .white_in(white0), .busy(busy0), .done(done0), .DO(DO0)
  );

  ws281x_frame_driver #(
    .NUM_LEDS(N1), .ADDR_W(AW1), .RGBW(1), .T0H_CYCLES(T0H1),
    .T1H_CYCLES(T1H1), .BIT_CYCLES(BC1), .RESET_CYCLES(RC1)
  ) dut_w (
    .clk(clk), .reset(reset), .start(start1), .brightness(bright1),
    .address(address1), .red_in(r1), .green_in(g1), .blue_in(b1),
    .white_in(w1), .busy(busy1), .done(done1), .DO(DO1)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Reference model: every bit's rise cycle and high width, plus done cycle.
  task automatic push_frame(input int k, input int s, input int n, input int bpp, input int b,
                            input int bitc, input int t0, input int t1, input int rc);
    int g, v;
    pulse_t p;
    g = 0;
    for (int led = 0; led < n; led++) begin
      for (int ch = 0; ch < bpp / 8; ch++) begin
        v = (snap[led][ch] * (b + 1)) / 256;
        for (int i = 7; i >= 0; i--) begin
          p.rise  = s + 2 + g * bitc;
          p.width = ((v >> i) & 1) ? t1 : t0;
          if (k == 0) q0.push_back(p); else q1.push_back(p);
          g++;
        end
      end
    end
    if (k == 0) dq0.push_back(s + 2 + n * bpp * bitc + rc);
    else        dq1.push_back(s + 2 + n * bpp * bitc + rc);
  endtask

  function automatic int exp_addr0(input int r);
    int g, led, bi;
    if (r < 2) return 0;
    g = (r - 2) / BC0;
    if (g >= N0 * 24) return 0;
    led = g / 24;
    bi  = g % 24;
    if (bi == 23 && led < N0 - 1) return led + 1;
    return led;
  endfunction

  task automatic snap_mem();
    for (int i = 0; i < 8; i++) begin
      snap[i][0] = int'(mem[i][31:24]);
      snap[i][1] = int'(mem[i][23:16]);
      snap[i][2] = int'(mem[i][15:8]);
      snap[i][3] = int'(mem[i][7:0]);
    end
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 8; i++) mem[i] = $urandom;
  endtask

  task automatic monitor(input int k);
    logic prev, d, dn;
    int hs;
    pulse_t p;
    prev = 1'b0;
    hs = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b0;
      end else begin
        d  = (k == 0) ? DO0 : DO1;
        dn = (k == 0) ? done0 : done1;
        if (d && !prev) hs = cyc;
        if (!d && prev) begin
          if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_pulse_dut%0d: got pulse rising at %0d, required none", k, hs);
          end else begin
            if (k == 0) p = q0.pop_front(); else p = q1.pop_front();
            check($sformatf("rise_cycle_dut%0d", k), hs, p.rise);
            check($sformatf("high_width_dut%0d", k), cyc - hs, p.width);
          end
        end
        prev = d;
        if (dn) begin
          if ((k == 0 && dq0.size() == 0) || (k == 1 && dq1.size() == 0)) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_done_dut%0d: got done at %0d, required none", k, cyc);
          end else if (k == 0) begin
            check("done_cycle_dut0", cyc, dq0.pop_front());
          end else begin
            check("done_cycle_dut1", cyc, dq1.pop_front());
          end
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) check("address0", int'(address0), act0 ? exp_addr0(cyc - frame_s0) : 0);
    end
  end

  task automatic start_frame0(input int b, output int s);
    start0  = 1'b1;
    bright0 = 8'(b);
    s = cyc + 1;
    snap_mem();
    push_frame(0, s, N0, 24, b, BC0, T0H0, T1H0, RC0);
    frame_s0 = s;
    act0 = 1'b1;
    @(negedge clk);
    start0  = 1'b0;
    bright0 = 8'($urandom);
  endtask

  task automatic finish_frame0(input int s);
    int d;
    d = s + 2 + N0 * 24 * BC0 + RC0;
    wait_until(s + 1); check("busy0_after_start", int'(busy0), 1);
    wait_until(d - 1); check("busy0_before_done", int'(busy0), 1);
    wait_until(d);     check("busy0_at_done", int'(busy0), 0);
    wait_until(d + 1); check("done0_one_cycle", int'(done0), 0);
  endtask

  task automatic run_frame0(input int b);
    int s;
    start_frame0(b, s);
    finish_frame0(s);
  endtask

  task automatic run_frame1(input int b);
    int s, d;
    start1  = 1'b1;
    bright1 = 8'(b);
    s = cyc + 1;
    snap[0][0] = int'(g1); snap[0][1] = int'(r1);
    snap[0][2] = int'(b1); snap[0][3] = int'(w1);
    push_frame(1, s, N1, 32, b, BC1, T0H1, T1H1, RC1);
    @(negedge clk);
    start1  = 1'b0;
    bright1 = 8'($urandom);
    d = s + 2 + N1 * 32 * BC1 + RC1;
    wait_until(s + 1); check("busy1_after_start", int'(busy1), 1);
    wait_until(s + 2 + 31 * BC1 + 1); check("address1_last_bit", int'(address1), 0);
    wait_until(d);     check("busy1_at_done", int'(busy1), 0);
    wait_until(d + 1);
  endtask

  initial begin
    int s, d;
    start0 = 1'b0; start1 = 1'b0; bright0 = 8'd0; bright1 = 8'd0;
    r1 = 8'd0; g1 = 8'd0; b1 = 8'd0; w1 = 8'd0;
    for (int i = 0; i < 8; i++) mem[i] = 32'd0;
    fork
      monitor(0);
      monitor(1);
    join_none
    repeat (3) @(negedge clk);
    check("reset_DO0", int'(DO0), 0);
    check("reset_busy0", int'(busy0), 0);
    check("reset_done0", int'(done0), 0);
    check("reset_address0", int'(address0), 0);
    check("reset_DO1", int'(DO1), 0);
    check("reset_busy1", int'(busy1), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) mem[i] = {8'hAA, 8'hFF, 8'h00, 8'h00};
    run_frame0(255);
    run_frame0(8'h80);
    for (int i = 0; i < 8; i++) mem[i] = {4{8'(i * 17)}};
    run_frame0(255);

    // Mid-frame disturbances, then a start held through the done cycle.
    rand_mem();
    start_frame0($urandom_range(1, 254), s);
    d = s + 2 + N0 * 24 * BC0 + RC0;
    wait_until(s + 10);
    mem[0] = $urandom;
    wait_until(s + 300);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_until(s + 1 + 302); check("busy0_ignored_start", int'(busy0), 1);
    wait_until(d - 5);
    rand_mem();
    bright0 = 8'd0;
    start0  = 1'b1;
    wait_until(d);
    check("busy0_at_done_b2b", int'(busy0), 0);
    s = d + 1;
    snap_mem();
    push_frame(0, s, N0, 24, 0, BC0, T0H0, T1H0, RC0);
    frame_s0 = s;
    @(negedge clk);
    start0 = 1'b0;
    finish_frame0(s);

    // Asynchronous reset in the middle of a frame.
    rand_mem();
    start_frame0($urandom_range(0, 255), s);
    wait_until(s + 2 + 60 * BC0);
    check("DO0_high_before_reset", int'(DO0), 1);
    #2 reset = 1'b1;
    q0.delete();
    dq0.delete();
    act0 = 1'b0;
    #1;
    check("async_reset_DO0", int'(DO0), 0);
    check("async_reset_busy0", int'(busy0), 0);
    check("async_reset_done0", int'(done0), 0);
    check("async_reset_address0", int'(address0), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    check("idle_after_reset_DO0", int'(DO0), 0);
    check("idle_after_reset_busy0", int'(busy0), 0);

    rand_mem();
    run_frame0($urandom_range(0, 255));

    g1 = 8'hAA; r1 = 8'hFF; b1 = 8'h00; w1 = 8'h0F;
    run_frame1(255);
    g1 = 8'($urandom); r1 = 8'($urandom); b1 = 8'($urandom); w1 = 8'($urandom);
    run_frame1($urandom_range(0, 255));

    repeat (20) @(negedge clk);
    check("pending_pulses0", q0.size(), 0);
    check("pending_pulses1", q1.size(), 0);
    check("pending_done0", dq0.size(), 0);
    check("pending_done1", dq1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
